// File: rtl/router_pkt_framer.sv
// router_pkt_framer: buffers one packet payload, then frames it onto the
// router byte input as header, payload and an even-XOR parity byte while
// honouring the router's busy back-pressure.
module router_pkt_framer #(
  parameter int unsigned DEPTH = 64
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_addr,
  input  logic [5:0] req_len,
  input  logic       req_inject_err,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic       busy,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  output logic       pkt_done,
  output logic       bad_req
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HDR,
    S_PAY,
    S_PAR,
    S_DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [1:0] addr_q, addr_n;
  logic [5:0] len_q, len_n;
  logic       inj_q, inj_n;
  logic [5:0] cnt, cnt_n;
  logic [5:0] rd, rd_n;
  logic [7:0] parity, parity_n;
  logic [7:0] pkt_data_n;
  logic       pkt_valid_n, pkt_done_n, bad_req_n;
  logic       buf_we;
  logic [7:0] buffer [DEPTH];

  logic       req_bad, last_wr, last_rd;
  logic [5:0] rd_nxt;

  assign req_bad = (req_addr == 2'd3) || (req_len == 6'd0);
  assign last_wr = pl_valid && (cnt == len_q - 6'd1);
  assign last_rd = (rd == len_q - 6'd1);
  assign rd_nxt  = rd + 6'd1;

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode; every bus-side move waits for a consume (busy low).
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (req_valid && !req_bad) state_nxt = S_LOAD;
      S_LOAD:  if (last_wr)               state_nxt = S_HDR;
      S_HDR:   if (!busy)                 state_nxt = S_PAY;
      S_PAY:   if (!busy && last_rd)      state_nxt = S_PAR;
      S_PAR:   if (!busy)                 state_nxt = S_DRAIN;
      S_DRAIN: if (!busy)                 state_nxt = S_IDLE;
      default:                            state_nxt = S_IDLE;
    endcase
  end

  // Output decode: ready strobes plus next values of the registered bus outputs.
  // The byte following a consumed one is fetched here so that it appears on
  // the same edge as the state change.
  always_comb begin
    req_ready   = (state == S_IDLE);
    pl_ready    = (state == S_LOAD);
    addr_n      = addr_q;
    len_n       = len_q;
    inj_n       = inj_q;
    cnt_n       = cnt;
    rd_n        = rd;
    parity_n    = parity;
    pkt_data_n  = pkt_data;
    pkt_valid_n = pkt_valid;
    pkt_done_n  = 1'b0;
    bad_req_n   = 1'b0;
    buf_we      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          addr_n    = req_addr;
          len_n     = req_len;
          inj_n     = req_inject_err;
          cnt_n     = '0;
          bad_req_n = req_bad;
        end
      end
      S_LOAD: begin
        if (pl_valid) begin
          buf_we = 1'b1;
          cnt_n  = cnt + 6'd1;
          if (last_wr) begin
            pkt_data_n  = {len_q, addr_q};
            pkt_valid_n = 1'b1;
          end
        end
      end
      S_HDR: begin
        if (!busy) begin
          parity_n   = pkt_data;
          pkt_data_n = buffer[0];
          rd_n       = '0;
        end
      end
      S_PAY: begin
        if (!busy) begin
          parity_n = parity ^ pkt_data;
          if (last_rd) begin
            pkt_data_n  = parity ^ pkt_data ^ {7'b0, inj_q};
            pkt_valid_n = 1'b0;
          end else begin
            pkt_data_n = buffer[rd_nxt];
            rd_n       = rd_nxt;
          end
        end
      end
      S_PAR: begin
        if (!busy) pkt_done_n = 1'b1;
      end
      S_DRAIN: ;
      default: ;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q    <= '0;
      len_q     <= '0;
      inj_q     <= 1'b0;
      cnt       <= '0;
      rd        <= '0;
      parity    <= '0;
      pkt_data  <= '0;
      pkt_valid <= 1'b0;
      pkt_done  <= 1'b0;
      bad_req   <= 1'b0;
    end else begin
      addr_q    <= addr_n;
      len_q     <= len_n;
      inj_q     <= inj_n;
      cnt       <= cnt_n;
      rd        <= rd_n;
      parity    <= parity_n;
      pkt_data  <= pkt_data_n;
      pkt_valid <= pkt_valid_n;
      pkt_done  <= pkt_done_n;
      bad_req   <= bad_req_n;
    end
  end

  // Payload store; not reset because every byte read is written first.
  always_ff @(posedge clock) begin
    if (buf_we) buffer[cnt] <= pl_data;
  end

endmodule

// File: tb/tb_router_pkt_framer.sv
// Scoreboard bench for router_pkt_framer: stimulus pushes expected bus bytes,
// a negedge monitor pops and compares each consumed byte.
module tb_router_pkt_framer;

  logic       clock = 1'b0;
  logic       resetn;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_addr;
  logic [5:0] req_len;
  logic       req_inject_err;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic       busy;
  logic [7:0] pkt_data;
  logic       pkt_valid;
  logic       pkt_done;
  logic       bad_req;

  router_pkt_framer #(.DEPTH(64)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_len        (req_len),
    .req_inject_err (req_inject_err),
    .pl_data        (pl_data),
    .pl_valid       (pl_valid),
    .pl_ready       (pl_ready),
    .busy           (busy),
    .pkt_data       (pkt_data),
    .pkt_valid      (pkt_valid),
    .pkt_done       (pkt_done),
    .bad_req        (bad_req)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  pl_buf [64];
  int unsigned stall  [65];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endfunction

  // Monitor: checks each consumed byte against the queue, stall stability and pkt_done.
  bit         par_pending = 0;
  bit         done_exp    = 0;
  bit         prev_hold   = 0;
  logic [7:0] prev_data;
  logic       prev_valid;
  always @(negedge clock) begin
    exp_t e;
    if (!resetn) begin
      par_pending = 0;
      done_exp    = 0;
      prev_hold   = 0;
    end else begin
      chk("pkt_done", pkt_done, done_exp);
      done_exp = 0;
      if (prev_hold) begin
        chk("stall_data", pkt_data, prev_data);
        chk("stall_valid", pkt_valid, prev_valid);
      end
      prev_hold  = busy && (pkt_valid || par_pending);
      prev_data  = pkt_data;
      prev_valid = pkt_valid;
      if ((pkt_valid || par_pending) && !busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h valid %0b, expected nothing at %0t",
                   pkt_data, pkt_valid, $time);
        end else begin
          e = exp_q.pop_front();
          chk("byte_valid", pkt_valid, e.v);
          chk("byte_data", pkt_data, e.d);
          if (!pkt_valid) done_exp = 1;
        end
        par_pending = pkt_valid;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_vals();
    chk("rst_pkt_data", pkt_data, 8'h00);
    chk("rst_pkt_valid", pkt_valid, 1'b0);
    chk("rst_pkt_done", pkt_done, 1'b0);
    chk("rst_bad_req", bad_req, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_pl_ready", pl_ready, 1'b0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    check_reset_vals();
    exp_q.delete();
    busy = 1'b0;
    pl_valid = 1'b0;
    req_valid = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic do_req(input logic [1:0] a, input logic [5:0] l, input logic inj);
    for (int i = 0; i < 200 && !req_ready; i++) tick();
    chk("req_ready_wait", req_ready, 1'b1);
    req_addr       = a;
    req_len        = l;
    req_inject_err = inj;
    req_valid      = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic push_exp(input int unsigned len, input logic [7:0] hdr, input logic [7:0] par);
    exp_q.push_back({1'b1, hdr});
    for (int unsigned i = 0; i < len; i++) exp_q.push_back({1'b1, pl_buf[i]});
    exp_q.push_back({1'b0, par});
  endtask

  // Writes n payload bytes; one idle cycle is inserted before byte index gap.
  task automatic do_load(input int unsigned n, input int unsigned gap);
    for (int unsigned i = 0; i < n; i++) begin
      if (i == gap) begin
        pl_valid = 1'b0;
        tick();
      end
      chk("pl_ready", pl_ready, 1'b1);
      pl_data  = pl_buf[i];
      pl_valid = 1'b1;
      tick();
    end
    pl_valid = 1'b0;
    pl_data  = 8'hEE;
  endtask

  // Drives busy per byte (header = index 0), consumes parity, checks drain timing.
  task automatic do_send(input int unsigned len);
    for (int unsigned k = 0; k <= len; k++) begin
      if (stall[k] > 0) begin
        busy = 1'b1;
        for (int unsigned s = 0; s < stall[k]; s++) tick();
        busy = 1'b0;
      end
      tick();
    end
    tick();
    chk("drain_req_ready", req_ready, 1'b0);
    tick();
    chk("idle_req_ready", req_ready, 1'b1);
  endtask

  task automatic load_basic();
    pl_buf[0] = 8'hA1;
    pl_buf[1] = 8'hB2;
    pl_buf[2] = 8'hC3;
  endtask

  task automatic clear_stall();
    for (int unsigned k = 0; k < 65; k++) stall[k] = 0;
  endtask

  task automatic illegal(input logic [1:0] a, input logic [5:0] l);
    do_req(a, l, 1'b0);
    chk("bad_req_pulse", bad_req, 1'b1);
    chk("bad_pl_ready", pl_ready, 1'b0);
    tick();
    chk("bad_req_clear", bad_req, 1'b0);
    chk("bad_stay_idle", req_ready, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    chk("bad_no_valid", pkt_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_len = '0; req_inject_err = 1'b0;
    pl_data = '0; pl_valid = 1'b0; busy = 1'b0;
    clear_stall();
    tick();
    tick();
    check_reset_vals();
    resetn = 1'b1;
    tick();

    // Basic packet: 0D A1 B2 C3 / DD
    load_basic();
    push_exp(3, 8'h0D, 8'hDD);
    do_req(2'd1, 6'd3, 1'b0);
    do_load(3, 1);
    do_send(3);

    // Busy stall: 3 cycles on header, 2 on B2
    clear_stall();
    stall[0] = 3;
    stall[2] = 2;
    push_exp(3, 8'h0D, 8'hDD);
    do_req(2'd1, 6'd3, 1'b0);
    do_load(3, 99);
    do_send(3);
    clear_stall();

    // Illegal requests
    illegal(2'd3, 6'd5);
    illegal(2'd0, 6'd0);

    // Maximum length: header FE, parity FE ^ 3F = C1
    for (int unsigned i = 0; i < 63; i++) pl_buf[i] = 8'(i);
    push_exp(63, 8'hFE, 8'hC1);
    do_req(2'd2, 6'd63, 1'b0);
    do_load(63, 99);
    do_send(63);

    // Parity injection: DD -> DC
    load_basic();
    push_exp(3, 8'h0D, 8'hDC);
    do_req(2'd1, 6'd3, 1'b1);
    do_load(3, 99);
    do_send(3);

    // Reset during LOAD after 2 of 5 bytes, then a clean packet
    pl_buf[0] = 8'h55; pl_buf[1] = 8'h66;
    do_req(2'd0, 6'd5, 1'b0);
    do_load(2, 99);
    do_reset();
    load_basic();
    push_exp(3, 8'h0D, 8'hDD);
    do_req(2'd1, 6'd3, 1'b0);
    do_load(3, 99);
    do_send(3);

    // Reset during PAY (header 12, then 11 consumed), then a clean packet
    pl_buf[0] = 8'h11; pl_buf[1] = 8'h22; pl_buf[2] = 8'h33; pl_buf[3] = 8'h44;
    push_exp(4, 8'h12, 8'h56);
    do_req(2'd2, 6'd4, 1'b0);
    do_load(4, 99);
    tick();
    tick();
    chk("pay_valid_before_rst", pkt_valid, 1'b1);
    do_reset();
    load_basic();
    push_exp(3, 8'h0D, 8'hDD);
    do_req(2'd1, 6'd3, 1'b0);
    do_load(3, 99);
    do_send(3);

    for (int i = 0; i < 5; i++) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_pkt_framer.md
# router_pkt_framer

Upstream packet source for the 1x3 router. It accepts a packet request (destination port, payload length), buffers the payload bytes, then drives the router's byte input and `pkt_valid` with a framed packet: header, payload, then an even-XOR parity byte. It honours the router's `busy` back-pressure and never starts a new packet until the router has finished the previous one.

## Interface
- `DEPTH` — 64 — payload buffer depth in bytes; must be ≥ 63, the maximum payload length.
- `clock`  in  1  single clock; all state changes on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  packet request present.
- `req_ready`  out  1  high only in IDLE.
- `req_addr`  in  2  destination port, 0..2; 3 is illegal.
- `req_len`  in  6  payload length, 1..63; 0 is illegal.
- `req_inject_err`  in  1  sampled with the request; if set, the parity byte's bit 0 is inverted.
- `pl_data`  in  8  payload byte.
- `pl_valid`  in  1  payload byte present.
- `pl_ready`  out  1  high only in LOAD.
- `busy`  in  1  router back-pressure; connects to router `busy`.
- `pkt_data`  out  8  connects to router `data_in`.
- `pkt_valid`  out  1  connects to router `pkt_valid`.
- `pkt_done`  out  1  one-cycle pulse when the parity byte has been consumed.
- `bad_req`  out  1  one-cycle pulse when an illegal request is dropped.

## Operation
- **States:** IDLE, LOAD, HDR, PAY, PAR, DRAIN.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, latch addr, len and inject.
  - If addr==3 or len==0: pulse `bad_req`, stay in IDLE, drop the request.
  - Otherwise go to LOAD.
- **LOAD**
  - `pl_ready`=1. Each `pl_valid` cycle writes `pl_data` to buffer[cnt] and increments cnt.
  - On the write with cnt==len-1, go to HDR.
- **"Consumed" rule:** a byte on `pkt_data` is consumed at a rising edge where `busy`==0. While `busy`==1, `pkt_data` and `pkt_valid` hold their values exactly.
- **HDR**
  - `pkt_data`={len,addr}, `pkt_valid`=1.
  - On consume: parity = header, rd index = 0, go to PAY.
- **PAY**
  - `pkt_data`=buffer[rd], `pkt_valid`=1.
  - On consume: parity ^= byte, rd++.
  - After byte len-1 is consumed, go to PAR.
- **PAR**
  - `pkt_data` = parity ^ {7'b0,inject}, `pkt_valid`=0.
  - On consume: pulse `pkt_done`, go to DRAIN.
- **DRAIN**
  - `pkt_valid`=0, `pkt_data` holds the parity byte.
  - Stay at least one cycle; then return to IDLE on the first cycle with `busy`==0. This covers the router's parity-check state.
- **Parity:** an 8-bit XOR of the header and all payload bytes.
- **Buffer:** written only in LOAD and read only in HDR/PAY/PAR. Load and send never overlap, so there is no pointer wrap.
- **Reset (async, any state):** everything is cleared; the partially loaded or partially sent packet is abandoned. No recovery of the router side is attempted; the router shares the same reset.

## Timing
- **Reset values:**
  - state=IDLE, `pkt_data`=8'h00, `pkt_valid`=0.
  - `pkt_done`=0, `bad_req`=0.
  - `req_ready`=1, `pl_ready`=0.
- **Registered vs. decoded outputs:**
  - `pkt_data`, `pkt_valid`, `pkt_done` and `bad_req` are registered and update on the same edge as the state transition.
  - `req_ready` and `pl_ready` are combinational decodes of the state.
- **Start latency:** request accepted at edge E → LOAD from E+1. The last payload write at edge L puts the header on the bus from L+1.
- **Back-pressure:** with `busy` never asserted, one byte is consumed per cycle. A packet of len N occupies the bus for N+2 cycles: `pkt_valid` is high for N+1 cycles, then one parity cycle with `pkt_valid` low.
- **`pkt_done`:** high in the cycle after the parity byte is consumed.
- **Next request:** not accepted before DRAIN exits, so the minimum inter-packet gap is 2 cycles with `pkt_valid`=0.
- **Simultaneous events:**
  - `req_valid` in a non-IDLE state is ignored.
  - `pl_valid` outside LOAD is ignored.
  - `busy` rising in the same cycle as a byte is first driven delays consumption; nothing is skipped or duplicated.

## Test plan
- **Basic packet:** addr=1, len=3, payload A1,B2,C3, `busy`=0 → bus shows 0D,A1,B2,C3 with `pkt_valid`=1, then DD with `pkt_valid`=0; one `pkt_done` pulse; `req_ready` returns high 2 cycles later.
- **Busy stall:** same packet, `busy` held high for 3 cycles while the header is on the bus and 2 cycles on byte B2 → each byte holds stable during its stall; sequence and parity unchanged (0D,A1,B2,C3,DD).
- **Illegal requests:** addr=3, len=5 → one `bad_req` pulse, `pl_ready` stays 0, `pkt_valid` never rises. Then len=0, addr=0 → same result.
- **Maximum length:** addr=2, len=63, payload 00..3E → header FE, 63 payload bytes in order, parity = FE XOR (XOR of 00..3E).
- **Parity injection:** the basic packet with `req_inject_err`=1 → parity byte DC.
- **Reset mid-operation:** assert `resetn`=0 during LOAD after 2 of 5 bytes, and again during PAY → outputs immediately take their reset values; the next legal request produces a correct, complete packet.
